// File: rtl/trap_vec_ctrl_pkg.sv
// Shared definitions for the trap vector controller: FSM encoding,
// fatal vector value and the vector address helper.
package minx_trap_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        REDIRECT_TRAP = 2'd1,
        REDIRECT_RTI  = 2'd2
    } trap_state_e;

    // Vector used when a trap cannot be serviced (stack overflow).
    localparam logic [31:0] FATAL_VEC = 32'd0;

    // Vector PC for source idx: base + ((idx+1) << shift), caller truncates.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] idx,
                                             input logic [4:0]  shift);
        vec_addr = base + ((idx + 32'd1) << shift);
    endfunction

endpackage

// File: rtl/trap_vec_ctrl_if.sv
// Redirect channel between the trap controller (master) and fetch (slave).
interface trap_vec_ctrl_if #(
    parameter int A = 16
) ();
    logic         redirect_valid;
    logic         redirect_ready;
    logic [A-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/trap_vec_ctrl_stack.sv
// trap_pc_stack: small LIFO of saved return PCs. Push beats pop when both
// are requested; push when full and pop when empty are ignored.
module trap_pc_stack #(
    parameter int A     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [A-1:0]             din_i,
    output logic [A-1:0]             top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] top_ptr_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign wr_ptr_s  = count_q[PW-1:0];
    assign top_ptr_s = count_q[PW-1:0] - {{(PW-1){1'b0}}, 1'b1};
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~push_i & ~empty_o;
    assign top_o     = mem_q[top_ptr_s];
    assign count_o   = count_q;

    // Occupancy update from the accepted push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push_s) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else if (do_pop_s) begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_s] <= din_i;
        end
    end

endmodule

// File: rtl/trap_vec_ctrl.sv
// trap_vec_ctrl: latches prioritised trap requests, computes the vector PC
// from a programmable base, keeps return PCs on a LIFO and issues a
// ready/valid redirect to fetch. Source 0 has the highest priority.
// Optional build macro TRAP_MASK_EN adds a trap_mask input and priority
// nesting (a trap in service masks itself and all lower priorities).
module trap_vec_ctrl
    import minx_trap_pkg::*;
#(
    parameter int A         = 16,
    parameter int NSRC      = 4,
    parameter int VEC_SHIFT = 10,
    parameter int INC       = 2,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC-1:0]          trap_req,
    output logic [NSRC-1:0]          trap_ack,
`ifdef TRAP_MASK_EN
    input  logic [NSRC-1:0]          trap_mask,
`endif
    input  logic [A-1:0]             pc,
    input  logic                     trap_after,
    input  logic                     rti_req,
    output logic                     rti_ack,
    input  logic                     vbase_we,
    input  logic [A-1:0]             vbase_wd,
    trap_vec_ctrl_if.master          rd,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     err
);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    trap_state_e      state_q, state_d;
    logic [A-1:0]     pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [A-1:0]     ret_q, ret_d;
    logic             fatal_q, fatal_d;
    logic             err_q, err_d;
    logic [A-1:0]     vbase_q;

    logic [NSRC-1:0]  elig_s;
    logic             any_s;
    logic [IW-1:0]    sel_s;
    logic             push_s;
    logic             pop_s;
    logic [NSRC-1:0]  trap_ack_s;
    logic             rti_ack_s;
    logic [A-1:0]     stk_top_s;
    logic             stk_full_s;
    logic             stk_empty_s;

    trap_pc_stack #(.A(A), .DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (ret_q),
        .top_o   (stk_top_s),
        .count_o (depth),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s)
    );

`ifdef TRAP_MASK_EN
    logic [IW-1:0]            lvl_top_s;
    logic [$clog2(DEPTH):0]   lvl_count_s;
    logic                     lvl_full_s;
    logic                     lvl_empty_s;
    logic [NSRC-1:0]          nest_mask_s;

    // Parallel stack of in-service source indices, pushed/popped with the PCs.
    trap_pc_stack #(.A(IW), .DEPTH(DEPTH)) u_lvl_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (idx_q),
        .top_o   (lvl_top_s),
        .count_o (lvl_count_s),
        .full_o  (lvl_full_s),
        .empty_o (lvl_empty_s)
    );

    // Mask the in-service level and everything of lower priority.
    always_comb begin
        nest_mask_s = {NSRC{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            if (!stk_empty_s && (IW'(k) >= lvl_top_s)) begin
                nest_mask_s[k] = 1'b1;
            end else begin
                nest_mask_s[k] = 1'b0;
            end
        end
    end

    assign elig_s = trap_req & ~trap_mask & ~nest_mask_s;
`else
    assign elig_s = trap_req;
`endif

    // Priority encoder: lowest set eligible index wins.
    always_comb begin
        any_s = 1'b0;
        sel_s = {IW{1'b0}};
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (elig_s[k]) begin
                any_s = 1'b1;
                sel_s = IW'(k);
            end else begin
                any_s = any_s;
            end
        end
    end

    // FSM next state, redirect target capture and accept-cycle actions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        idx_d      = idx_q;
        ret_d      = ret_q;
        fatal_d    = fatal_q;
        err_d      = err_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        trap_ack_s = {NSRC{1'b0}};
        rti_ack_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    idx_d   = sel_s;
                    ret_d   = trap_after ? (pc + A'(INC)) : pc;
                    state_d = REDIRECT_TRAP;
                    if (stk_full_s) begin
                        pc_d    = A'(FATAL_VEC);
                        fatal_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = A'(vec_addr(32'(vbase_q), 32'(sel_s), 5'(VEC_SHIFT)));
                        fatal_d = 1'b0;
                    end
                end else if (rti_req) begin
                    state_d = REDIRECT_RTI;
                    if (stk_empty_s) begin
                        pc_d    = A'(FATAL_VEC);
                        fatal_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = stk_top_s;
                        fatal_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT_TRAP: begin
                if (rd.redirect_ready) begin
                    push_s     = ~fatal_q;
                    trap_ack_s = NSRC'(1) << idx_q;
                    state_d    = IDLE;
                end else begin
                    state_d = REDIRECT_TRAP;
                end
            end
            REDIRECT_RTI: begin
                if (rd.redirect_ready) begin
                    pop_s     = ~fatal_q;
                    rti_ack_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = REDIRECT_RTI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d != IDLE);
    end

    // Controller state and redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= {A{1'b0}};
            valid_q <= 1'b0;
            idx_q   <= {IW{1'b0}};
            ret_q   <= {A{1'b0}};
            fatal_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ret_q   <= ret_d;
            fatal_q <= fatal_d;
            err_q   <= err_d;
        end
    end

    // Vector base register, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vbase_q <= {A{1'b0}};
        end else if (vbase_we) begin
            vbase_q <= vbase_wd;
        end
    end

    assign rd.redirect_valid = valid_q;
    assign rd.redirect_pc    = pc_q;
    assign trap_ack          = trap_ack_s;
    assign rti_ack           = rti_ack_s;
    assign err               = err_q;

endmodule

// File: tb/tb_trap_vec_ctrl.sv
// Scoreboard bench for trap_vec_ctrl (default build): a driver issues trap /
// rti transactions, a reference model predicts each redirect, and a monitor
// compares every accepted redirect against the predicted queue.
module tb_trap_vec_ctrl;
    localparam int A = 16, NSRC = 4, VEC_SHIFT = 10, INC = 2, DEPTH = 4;

    typedef struct {
        bit          is_trap;
        logic [15:0] pc;
        logic [3:0]  ack;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  trap_req;
    logic [3:0]  trap_ack;
    logic [15:0] pc_in;
    logic        trap_after;
    logic        rti_req;
    logic        rti_ack;
    logic        vbase_we;
    logic [15:0] vbase_wd;
    logic [2:0]  depth;
    logic        err;

    trap_vec_ctrl_if #(.A(A)) bus ();

    trap_vec_ctrl #(.A(A), .NSRC(NSRC), .VEC_SHIFT(VEC_SHIFT), .INC(INC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trap_req   (trap_req),
        .trap_ack   (trap_ack),
        .pc         (pc_in),
        .trap_after (trap_after),
        .rti_req    (rti_req),
        .rti_ack    (rti_ack),
        .vbase_we   (vbase_we),
        .vbase_wd   (vbase_wd),
        .rd         (bus),
        .depth      (depth),
        .err        (err)
    );

    exp_t        exp_q[$];
    logic [15:0] m_stack[$];
    bit          m_err;
    logic [15:0] m_vbase;
    int          tests;
    int          fails;
    bit          hold_rdy;
    bit          abort;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: a trap goes to the lowest requesting source.
    task automatic model_trap(input logic [3:0] req, input logic [15:0] p, input bit after);
        exp_t e;
        int   i;
        i = 0;
        while (!req[i]) i++;
        e.is_trap = 1'b1;
        e.ack     = 4'(1 << i);
        if (m_stack.size() == DEPTH) begin
            e.pc  = 16'h0000;
            m_err = 1'b1;
        end else begin
            e.pc = m_vbase + 16'((i + 1) << VEC_SHIFT);
            m_stack.push_back(after ? 16'(p + 16'(INC)) : p);
        end
        exp_q.push_back(e);
    endtask

    task automatic model_rti();
        exp_t e;
        e.is_trap = 1'b0;
        e.ack     = 4'h0;
        if (m_stack.size() == 0) begin
            e.pc  = 16'h0000;
            m_err = 1'b1;
        end else begin
            e.pc = m_stack.pop_back();
        end
        exp_q.push_back(e);
    endtask

    // Fetch side: random back-pressure, can be forced off.
    initial begin
        bus.redirect_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.redirect_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops a prediction for each accepted redirect, checks hold stability.
    initial begin
        exp_t        e;
        bit          stalled;
        logic [15:0] prev_pc;
        stalled = 1'b0;
        prev_pc = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.redirect_valid) begin
                if (stalled) check("pc_stable", 32'(bus.redirect_pc), 32'(prev_pc));
                if (bus.redirect_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_redirect", 32'(bus.redirect_pc), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check(e.is_trap ? "trap_pc" : "rti_pc", 32'(bus.redirect_pc), 32'(e.pc));
                        check("trap_ack", 32'(trap_ack), 32'(e.ack));
                        check("rti_ack", 32'(rti_ack), e.is_trap ? 32'd0 : 32'd1);
                    end
                end else begin
                    stalled = 1'b1;
                    prev_pc = bus.redirect_pc;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Wait for the requested acknowledge; optionally write vbase while the redirect is pending.
    task automatic wait_ack(input bit want_trap, input bit do_wr, input logic [15:0] wv, output bit wrote);
        bit ok;
        ok    = 1'b0;
        wrote = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            vbase_we = 1'b0;
            if (do_wr && !wrote && bus.redirect_valid) begin
                vbase_we = 1'b1;
                vbase_wd = wv;
                wrote    = 1'b1;
            end
            if (want_trap ? (trap_ack != 4'h0) : rti_ack) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        vbase_we = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            abort = 1'b1;
            $display("FAIL ack_timeout: got no %s ack, expected one within 300 cycles",
                     want_trap ? "trap" : "rti");
        end
    endtask

    task automatic check_state();
        check("depth", 32'(depth), 32'(m_stack.size()));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_trap(input logic [3:0] req, input logic [15:0] p, input bit after,
                           input bit do_wr, input logic [15:0] wv);
        bit wrote;
        trap_req   = req;
        pc_in      = p;
        trap_after = after;
        model_trap(req, p, after);
        wait_ack(1'b1, do_wr, wv, wrote);
        trap_req = 4'h0;
        pc_in    = 16'($urandom);
        if (wrote) m_vbase = wv;
        check_state();
    endtask

    task automatic do_rti();
        bit wrote;
        rti_req = 1'b1;
        model_rti();
        wait_ack(1'b0, 1'b0, 16'h0, wrote);
        rti_req = 1'b0;
        check_state();
    endtask

    task automatic do_both(input logic [3:0] req, input logic [15:0] p, input bit after);
        bit wrote;
        trap_req   = req;
        rti_req    = 1'b1;
        pc_in      = p;
        trap_after = after;
        model_trap(req, p, after);
        model_rti();
        wait_ack(1'b1, 1'b0, 16'h0, wrote);
        trap_req = 4'h0;
        if (!abort) wait_ack(1'b0, 1'b0, 16'h0, wrote);
        rti_req = 1'b0;
        check_state();
    endtask

    task automatic set_vbase(input logic [15:0] v);
        vbase_we = 1'b1;
        vbase_wd = v;
        @(posedge clk);
        #1;
        vbase_we = 1'b0;
        m_vbase  = v;
    endtask

    initial begin
        int r;
        tests = 0; fails = 0; abort = 1'b0; hold_rdy = 1'b0;
        m_err = 1'b0; m_vbase = 16'h0;
        rst_n = 1'b0; trap_req = 4'h0; pc_in = 16'h0; trap_after = 1'b0;
        rti_req = 1'b0; vbase_we = 1'b0; vbase_wd = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_pc", 32'(bus.redirect_pc), 32'd0);
        check("rst_acks", 32'({trap_ack, rti_ack}), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_trap(4'b0100, 16'h0100, 1'b0, 1'b0, 16'h0);
        do_trap(4'b0110, 16'h1230, 1'b1, 1'b0, 16'h0);
        do_rti();
        set_vbase(16'hF000);
        do_trap(4'b1000, 16'h4444, 1'b0, 1'b1, 16'h2000);
        do_both(4'b0001, 16'h5550, 1'b1);

        for (int t = 0; t < 200 && !abort; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                if (r == 0) set_vbase(16'($urandom));
                do_trap(4'($urandom_range(1, 15)), 16'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) == 0), 16'($urandom));
            end else if (r <= 8) begin
                do_rti();
            end else begin
                do_both(4'($urandom_range(1, 15)), 16'($urandom), 1'($urandom));
            end
        end

        if (!abort) begin
            hold_rdy = 1'b1;
            @(posedge clk);
            #1;
            trap_req = 4'b0001;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bus.redirect_valid) break;
            end
            rst_n = 1'b0;
            #1;
            check("rst_mid_valid", 32'(bus.redirect_valid), 32'd0);
            check("rst_mid_pc", 32'(bus.redirect_pc), 32'd0);
            check("rst_mid_acks", 32'({trap_ack, rti_ack}), 32'd0);
            check("rst_mid_depth", 32'(depth), 32'd0);
            check("rst_mid_err", 32'(err), 32'd0);
            trap_req = 4'h0;
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_vec_ctrl.md
Name: trap_vec_ctrl

Overview:
- Sequential successor to the Minx16 combinational trap-address mux.
- Latches prioritised trap requests from NSRC sources and computes the vector PC from a programmable base.
- Saves the return PC on a DEPTH-entry LIFO, so nested traps and return-from-trap work.
- Issues a ready/valid redirect to fetch.

Parameters:
- A, 16, address width.
- NSRC, 4, number of trap sources; index 0 has highest priority.
- VEC_SHIFT, 10, log2 of vector spacing (0x400).
- INC, 2, instruction size added for the saved return PC.
- DEPTH, 4, saved-PC stack entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- trap_req  in  NSRC  level trap requests, held until acked.
- trap_ack  out  NSRC  one-hot pulse when a trap's redirect is accepted.
- pc  in  A  PC of the current instruction.
- trap_after  in  1  1: save pc+INC as return PC; 0: save pc.
- rti_req  in  1  return-from-trap request, level, held until rti_ack.
- rti_ack  out  1  pulse when the return redirect is accepted.
- vbase_we  in  1  write enable for the vector base.
- vbase_wd  in  A  vector base write data.
- redirect_valid  out  1  redirect PC is valid.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  A  target PC.
- depth  out  clog2(DEPTH)+1  current nesting depth.
- err  out  1  sticky fault flag.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - redirect_valid=0, redirect_pc=0, trap_ack=0, rti_ack=0, depth=0, err=0.
  - vbase=0, stack contents don't-care.
  - Reset asserted mid-REDIRECT drops the redirect immediately; nothing is pushed or popped.
- States: IDLE, REDIRECT_TRAP, REDIRECT_RTI.
- IDLE, any trap_req bit set:
  - Select the lowest set index i.
  - Register redirect_pc = vbase + ((i+1) << VEC_SHIFT), truncated mod 2^A.
  - Capture ret = trap_after ? pc+INC : pc (mod 2^A).
  - Go to REDIRECT_TRAP. redirect_valid rises the next cycle (1-cycle latency).
- IDLE, no trap, rti_req=1:
  - If depth>0: redirect_pc = top of stack; go to REDIRECT_RTI.
  - If depth==0: redirect_pc = 0, err set; go to REDIRECT_RTI with no pop.
- Trap and rti_req in the same IDLE cycle: the trap wins. rti_req stays pending and is serviced after the trap completes.
- REDIRECT_*:
  - redirect_valid=1; redirect_pc held stable until accepted.
  - trap_req and pc changes are ignored (the selection is frozen).
  - On valid&ready: push ret and depth++ (trap), or pop and depth-- (rti). Pulse trap_ack[i] or rti_ack for exactly that cycle; return to IDLE.
  - Back-to-back requests re-arbitrate in IDLE, giving a minimum 2-cycle spacing.
- Stack full (depth==DEPTH) when a trap is selected:
  - redirect_pc forced to 0 (fatal vector); err set; no push; trap still acked.
- err clears only on reset.
- vbase_we is honoured in any state. It takes effect for vectors computed from the next cycle on and does not alter a pending redirect_pc.

Optional Feature:
- Macro TRAP_MASK_EN.
- When defined:
  - Add input trap_mask [NSRC-1:0]; a source is eligible only if trap_req & ~trap_mask.
  - Any trap accepted while depth>0 masks sources with index ≥ the in-service index until its rti. This gives priority nesting; an in-service level is tracked per stack entry.
- When undefined: no trap_mask port; all sources always eligible; any priority may nest.

Decomposition:
- Package minx_trap_pkg holds:
  - State enum encoding (IDLE=2'd0, REDIRECT_TRAP=2'd1, REDIRECT_RTI=2'd2).
  - FATAL_VEC=0.
  - A function vec_addr(base, idx, shift).
- Sub-module trap_pc_stack: parametrised LIFO (A, DEPTH) with push, pop, top, count, full, empty.
- The arbiter is an inline priority encoder.

Test Plan:
- vbase=0; pulse-hold trap_req=4'b0100 → redirect_pc=0x0C00 one cycle later. Hold ready=0 for 3 cycles: valid and PC stay stable. ready=1 → trap_ack=4'b0100 for one cycle, depth=1.
- trap_req=4'b0110, pc=0x1230, trap_after=1 → vector 0x0800, saved 0x1232. Then rti_req → redirect_pc=0x1232, rti_ack, depth=0.
- vbase=0xF000, trap index 3 → vector 0x0000 (wrap mod 2^16). Write vbase=0x2000 during REDIRECT → pending redirect_pc unchanged.
- Nest 4 traps (depth=4), then a 5th → redirect_pc=0x0000, err=1, depth stays 4. Four rti pops return PCs in LIFO order.
- rti_req with depth=0 → redirect_pc=0, err=1. Trap and rti in the same cycle → trap serviced first, rti next.
- Assert rst_n low while redirect_valid=1 → outputs at their reset values immediately; no ack pulse.
